// File: rtl/hamming_norm_sched.sv
// Shared-stage scheduler: accepts one pixel's vector of 4-bit census Hamming costs, normalizes
// the lanes serially through a single lookup stage and hands the assembled 7-bit vector
// downstream over a valid/ready handshake.
module hamming_norm_sched #(
  parameter int unsigned NUM_DISP = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clken,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [4*NUM_DISP-1:0]   i_in_cost,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [7*NUM_DISP-1:0]   o_out_cost,
  output logic                    o_out_ovf,
  output logic                    o_busy,
  output logic [15:0]             o_pix_cnt
);

  localparam int unsigned IdxW = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DISP - 1);

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [4*NUM_DISP-1:0]   r_in_cost;
  logic [7*NUM_DISP-1:0]   r_out_cost;
  logic [IdxW-1:0]         r_idx;
  logic                    r_ovf_acc;
  logic                    r_out_ovf;
  logic [15:0]             r_pix_cnt;

  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic                    w_last;
  logic [3:0]              w_code;
  logic [6:0]              w_norm;
  logic                    w_code_ovf;

  // Fixed-point map with 64 = 1.0; codes above 9 are out of range and flagged.
  function automatic logic [6:0] norm_fn(input logic [3:0] code);
    logic [6:0] val;
    case (code)
      4'd0:    val = 7'd64;
      4'd1:    val = 7'd60;
      4'd2:    val = 7'd56;
      4'd3:    val = 7'd53;
      4'd4:    val = 7'd49;
      4'd5:    val = 7'd46;
      4'd6:    val = 7'd43;
      4'd7:    val = 7'd41;
      4'd8:    val = 7'd38;
      4'd9:    val = 7'd36;
      default: val = 7'd0;
    endcase
    return val;
  endfunction

  assign w_in_xfer  = (r_state == StIdle) && i_in_valid && i_clken;
  assign w_out_xfer = (r_state == StOut) && i_out_ready && i_clken;
  assign w_last     = (r_state == StRun) && (r_idx == LastIdx);
  assign w_code     = r_in_cost[int'(r_idx) * 4 +: 4];
  assign w_norm     = norm_fn(w_code);
  assign w_code_ovf = (w_code > 4'd9);

  // FSM state register; clken low freezes the schedule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else if (i_clken) begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE -> RUN on accept, RUN -> OUT after last lane, OUT -> IDLE on handoff.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_in_xfer) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StOut;
      StOut:   if (w_out_xfer) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: capture on accept, then one lane per enabled cycle into the output vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_cost  <= '0;
      r_out_cost <= '0;
      r_idx      <= '0;
      r_ovf_acc  <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else if (i_clken) begin
      if (w_in_xfer) begin
        // Output register deliberately left alone so the previous result stays visible.
        r_in_cost <= i_in_cost;
        r_idx     <= '0;
        r_ovf_acc <= 1'b0;
      end else if (r_state == StRun) begin
        r_out_cost[int'(r_idx) * 7 +: 7] <= w_norm;
        r_idx     <= r_idx + 1'b1;
        r_ovf_acc <= r_ovf_acc | w_code_ovf;
        if (w_last) begin
          r_out_ovf <= r_ovf_acc | w_code_ovf;
        end
      end
    end
  end

  // Completed-transfer counter, wraps modulo 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_cnt <= '0;
    end else if (w_out_xfer) begin
      r_pix_cnt <= r_pix_cnt + 16'd1;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StOut);
  assign o_busy      = (r_state != StIdle);
  assign o_out_cost  = r_out_cost;
  assign o_out_ovf   = r_out_ovf;
  assign o_pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_hamming_norm_sched.sv
// Scoreboard bench for hamming_norm_sched with NUM_DISP = 8: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every output transfer.
module tb_hamming_norm_sched;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clken = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [4*N-1:0] in_cost = '0;
  logic          in_ready;
  logic          out_valid;
  logic [7*N-1:0] out_cost;
  logic          out_ovf;
  logic          busy;
  logic [15:0]   pix_cnt;

  hamming_norm_sched #(.NUM_DISP(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_clken     (clken),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_cost   (in_cost),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_cost  (out_cost),
    .o_out_ovf   (out_ovf),
    .o_busy      (busy),
    .o_pix_cnt   (pix_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7*N-1:0] cost;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_pix = 0;

  // Hand-computed vectors; lane 0 is the rightmost field.
  localparam logic [4*N-1:0] RampIn = 32'h7654_3210;
  localparam logic [7*N-1:0] RampOut =
    {7'd41, 7'd43, 7'd46, 7'd49, 7'd53, 7'd56, 7'd60, 7'd64};
  localparam logic [4*N-1:0] OvfIn = 32'h0000_FA98;
  localparam logic [7*N-1:0] OvfOut =
    {7'd64, 7'd64, 7'd64, 7'd64, 7'd0, 7'd0, 7'd36, 7'd38};
  localparam logic [4*N-1:0] BpIn = 32'h2345_6789;
  localparam logic [7*N-1:0] BpOut =
    {7'd56, 7'd53, 7'd49, 7'd46, 7'd43, 7'd41, 7'd38, 7'd36};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare on every cycle in which an output transfer is about to happen.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && clken) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_cost), 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_cost", 64'(out_cost), 64'(e.cost));
        check("out_ovf", 64'(out_ovf), 64'(e.ovf));
        check("pix_cnt_at_xfer", 64'(pix_cnt), 64'(exp_pix[15:0]));
        exp_pix++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4*N-1:0] cost, input logic [7*N-1:0] ec, input logic eovf,
                      output int acc);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    check("send_timeout", 64'(n >= 200), 64'h0);
    e.cost = ec;
    e.ovf  = eovf;
    sb.push_back(e);
    in_valid = 1'b1;
    in_cost  = cost;
    step();
    acc      = cyc;
    in_valid = 1'b0;
    in_cost  = '1;  // garbage after the accept edge must not reach the pixel in flight
  endtask

  task automatic wait_out(input int acc, output int lat);
    int n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    check("out_valid_timeout", 64'(n >= 200), 64'h0);
    lat = cyc - acc;
  endtask

  initial begin
    int acc, lat;
    int accs[4];

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_cost", 64'(out_cost), 64'h0);
    check("rst_out_ovf", 64'(out_ovf), 64'h0);
    check("rst_pix_cnt", 64'(pix_cnt), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    step();
    rst = 1'b1;
    step();

    // Ramp
    send(RampIn, RampOut, 1'b0, acc);
    wait_out(acc, lat);
    check("ramp_latency", 64'(lat), 64'd8);
    step();
    check("ramp_pix_cnt", 64'(pix_cnt), 64'd1);
    check("ramp_in_ready", 64'(in_ready), 64'h1);

    // Overflow, then a clean pixel clears the flag
    send(OvfIn, OvfOut, 1'b1, acc);
    wait_out(acc, lat);
    step();
    send(RampIn, RampOut, 1'b0, acc);
    wait_out(acc, lat);
    step();

    // Backpressure for 20 cycles
    out_ready = 1'b0;
    send(BpIn, BpOut, 1'b0, acc);
    wait_out(acc, lat);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_out_cost", 64'(out_cost), 64'(BpOut));
      check("bp_in_ready", 64'(in_ready), 64'h0);
      check("bp_pix_cnt", 64'(pix_cnt), 64'd3);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(out_valid), 64'h0);
    check("bp_release_pix_cnt", 64'(pix_cnt), 64'd4);

    // in_valid with clken low in IDLE is ignored
    clken    = 1'b0;
    in_valid = 1'b1;
    in_cost  = RampIn;
    repeat (3) step();
    check("clken_idle_busy", 64'(busy), 64'h0);
    check("clken_idle_ready", 64'(in_ready), 64'h1);
    in_valid = 1'b0;
    clken    = 1'b1;
    step();
    check("clken_idle_no_accept", 64'(busy), 64'h0);

    // Three-cycle clken gap mid-RUN
    send(RampIn, RampOut, 1'b0, acc);
    repeat (3) step();
    clken = 1'b0;
    repeat (3) step();
    clken = 1'b1;
    wait_out(acc, lat);
    check("gap_latency", 64'(lat), 64'd11);
    step();
    check("gap_pix_cnt", 64'(pix_cnt), 64'd5);

    // Reset mid-RUN at lane 3
    send(RampIn, RampOut, 1'b0, acc);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'h0);
    check("mid_rst_out_cost", 64'(out_cost), 64'h0);
    check("mid_rst_out_ovf", 64'(out_ovf), 64'h0);
    check("mid_rst_pix_cnt", 64'(pix_cnt), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_in_ready", 64'(in_ready), 64'h1);
    sb.delete();
    exp_pix = 0;
    step();
    rst = 1'b1;
    step();
    send(RampIn, RampOut, 1'b0, acc);
    wait_out(acc, lat);
    step();
    check("post_rst_pix_cnt", 64'(pix_cnt), 64'd1);

    // Back-to-back throughput with in_valid held high
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      exp_t e;
      while (!in_ready && n < 200) begin
        step();
        n++;
      end
      check("b2b_timeout", 64'(n >= 200), 64'h0);
      e.cost = BpOut;
      e.ovf  = 1'b0;
      sb.push_back(e);
      in_valid = 1'b1;
      in_cost  = BpIn;
      step();
      accs[i] = cyc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("b2b_spacing", 64'(accs[i] - accs[i-1]), 64'd10);
    end
    wait_out(accs[3], lat);
    step();
    check("b2b_pix_cnt", 64'(pix_cnt), 64'd5);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_norm_sched.md
# hamming_norm_sched

Time-multiplexed scheduler that normalizes a full disparity vector of census Hamming costs through one shared normalization stage. It accepts one pixel's NUM_DISP 4-bit Hamming costs per handshake and converts them serially, one lane per enabled cycle. It assembles the 7-bit normalized costs into an output vector and presents it downstream with a valid/ready handshake. It sits between the census/Hamming stage and the cost-aggregation stage of the disparity-map pipeline.

## Interface
- NUM_DISP, 8: disparity candidates per pixel; legal range 2..64.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clken  input  1  global pipeline enable; when low, all state holds.
- in_valid  input  1  in_cost is valid.
- in_ready  output  1  scheduler can accept a pixel.
- in_cost  input  4*NUM_DISP  Hamming costs; lane d is bits [4d+3:4d].
- out_valid  output  1  out_cost is complete.
- out_ready  input  1  downstream accepts out_cost.
- out_cost  output  7*NUM_DISP  normalized costs; lane d is bits [7d+6:7d].
- out_ovf  output  1  at least one lane of this pixel had a code greater than 9.
- busy  output  1  state is not IDLE.
- pix_cnt  output  16  count of completed output transfers; wraps from 0xFFFF to 0.

## Operation
- FSM has three states, IDLE, RUN and OUT; reset state is IDLE.
- in_ready is 1 exactly when state is IDLE, decoded from state and independent of clken.
- out_valid is 1 exactly when state is OUT.
- Normalization map, applied to codes 0..9: 0→64, 1→60, 2→56, 3→53, 4→49, 5→46, 6→43, 7→41, 8→38, 9→36. Codes 10..15 map to 0 and set the ovf flag.
- IDLE: an input transfer is in_valid & in_ready & clken at a clock edge.
  - On a transfer, capture in_cost into the input register, clear lane index idx to 0, clear the ovf accumulator, and move to RUN.
  - The output register is not cleared on entry to RUN.
- RUN: each clken edge normalizes lane idx of the captured vector and writes the result into out_cost lane idx.
  - ovf accumulates code>9 for each lane processed.
  - idx increments each clken edge. On the edge that processes lane NUM_DISP-1, move to OUT and latch out_ovf from the accumulator.
- OUT: an output transfer is out_valid & out_ready & clken at a clock edge.
  - On a transfer, pix_cnt increments and the state returns to IDLE.
  - out_cost and out_ovf hold their values until they are overwritten by the next pixel.
- clken low: FSM, idx, registers and pix_cnt all hold, and no transfer occurs regardless of valid/ready.
- in_cost is sampled only at the transfer edge; later changes on in_cost have no effect on the pixel in flight.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs go to their reset values. The pixel in flight is discarded and not counted.
- Width rules:
  - idx is clog2(NUM_DISP) bits.
  - pix_cnt is a 16-bit modular counter.
  - Normalized values are 7-bit unsigned, fixed point with 64 = 1.0.

## Timing
- Reset values: out_valid 0, out_cost 0, out_ovf 0, pix_cnt 0, busy 0, in_ready 1.
- Latency with clken held high: input transfer at edge E0; lanes 0..N-1 are written at edges E1..EN; out_valid rises after EN, i.e. N cycles after acceptance.
- The earliest output transfer is at EN+1. in_ready is 1 after that edge, so the next acceptance is at EN+2.
- Throughput is one pixel per NUM_DISP+2 cycles.
- Each cycle with clken low stretches latency by exactly one cycle, at any point.
- Backpressure: out_ready low holds OUT indefinitely; in_ready stays 0 throughout.
- No combinational path exists from in_valid or out_ready to in_ready or out_valid.

## Test plan
- Ramp, NUM_DISP=8: in_cost lanes 0..7 = 0,1,2,3,4,5,6,7, out_ready=1 → out_valid rises 8 cycles after acceptance; lanes = 64,60,56,53,49,46,43,41; out_ovf=0; pix_cnt=1.
- Overflow: lanes = 8,9,10,15,0,0,0,0 → lanes = 38,36,0,0,64,64,64,64; out_ovf=1. A following clean pixel returns out_ovf=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_cost stable, in_ready=0, pix_cnt unchanged; transfer completes on the first edge with out_ready=1.
- clken gaps: deassert clken for 3 cycles in the middle of RUN → out_valid is delayed by exactly 3 cycles and results are identical to the gap-free run. in_valid with clken=0 in IDLE is not accepted.
- Reset mid-RUN at lane 3 → outputs return to reset values immediately; the next pixel completes normally and pix_cnt=1.
- Counter wrap: 65536 back-to-back pixels → pix_cnt returns to 0; spacing between acceptances is 10 cycles.
